window_sequencer: RTL and testbench

WINDOW_SEQUENCER -- requirements
Module: window_sequencer

---
 rtl/window_sequencer.sv | 142 ++++++++++++++
 tb/tb_window_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_sequencer.sv
// ---------------------------------------------------------------------------
// window_sequencer
//   Turns a raster-order pixel stream into a stream of 3x3 pixel windows.
//   Two IMG_W-byte line buffers hold the two previous rows. Each accepted
//   pixel shifts one column into a 3x3 register window. A window is emitted
//   once the bottom-right pixel sits at row >= 2 and col >= 2.
//
// Parameters
//   IMG_W, IMG_H : image width/height in pixels (3..1024 each)
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : in_data carries a pixel
//   in_data    : 8-bit pixel, raster order
//   in_ready   : pixel accepted this cycle when in_valid is also high
//   win_valid  : win_data carries a window
//   win_data   : 72-bit window, byte Bij at [8*(3i+j) +: 8]
//                (i = row, oldest first; j = column, leftmost first)
//   win_ready  : downstream consumes the window
//   frame_done : one-cycle pulse after the last pixel of a frame
//
// Configuration
//   WIN_STRIDE2_EN : when defined, emit only when (row-2) and (col-2) are
//                    both even (stride 2). Otherwise every position emits.
// ---------------------------------------------------------------------------
module window_sequencer #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        win_valid,
  output logic [71:0] win_data,
  input  logic        win_ready,
  output logic        frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          win_valid_q, win_valid_d;
  logic          frame_done_q, frame_done_d;
  logic [7:0]    win_q [3][3];
  logic [7:0]    win_d [3][3];

  // Line buffers: lb1 holds row r-1, lb2 holds row r-2 at each column.
  logic [7:0]    lb1_mem [IMG_W];
  logic [7:0]    lb2_mem [IMG_W];
  logic [7:0]    lb1_rd, lb2_rd;

  logic          accept, consume, col_last, row_last, emit;

  // Only a held, unconsumed window can stall the input.
  assign in_ready = ~win_valid_q | win_ready;
  assign accept   = in_valid & in_ready;
  assign consume  = win_valid_q & win_ready;
  assign col_last = (col_q == COL_LAST);
  assign row_last = (row_q == ROW_LAST);
  assign lb1_rd   = lb1_mem[col_q];
  assign lb2_rd   = lb2_mem[col_q];

  // Rows 0 and 1 never emit, so stale line-buffer data from a previous
  // frame (or from before reset) can never reach an emitted window.
`ifdef WIN_STRIDE2_EN
  assign emit = (row_q >= RW'(2)) & (col_q >= CW'(2)) & ~row_q[0] & ~col_q[0];
`else
  assign emit = (row_q >= RW'(2)) & (col_q >= CW'(2));
`endif

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    win_d        = win_q;
    win_valid_d  = win_valid_q;
    frame_done_d = 1'b0;
    if (accept) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
      // Shift left by one column; the new column enters at j = 2.
      for (int i = 0; i < 3; i++) begin
        win_d[i][0] = win_q[i][1];
        win_d[i][1] = win_q[i][2];
      end
      win_d[0][2]  = lb2_rd;
      win_d[1][2]  = lb1_rd;
      win_d[2][2]  = in_data;
      // An accept while valid implies a consume, so emit alone decides.
      win_valid_d  = emit;
      frame_done_d = col_last & row_last;
    end else if (consume) begin
      win_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          win_q[i][j] <= 8'h00;
        end
      end
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      win_q        <= win_d;
    end
  end

  // Line-buffer contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb2_mem[col_q] <= lb1_rd;
      lb1_mem[col_q] <= in_data;
    end
  end

  for (genvar gi = 0; gi < 9; gi++) begin : g_pack
    assign win_data[8*gi +: 8] = win_q[gi / 3][gi % 3];
  end

  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_window_sequencer.sv
// ---------------------------------------------------------------------------
// tb_window_sequencer
//   Drives a 4x4 instance with directed streams (table + hand sequences) and
//   a 28x28 instance with random throttling. A scoreboard per instance keeps
//   a full-image reference, pushes the expected window on each accept and
//   pops/compares on each consume. Honours WIN_STRIDE2_EN.
// ---------------------------------------------------------------------------
module tb_window_sequencer;

`ifdef WIN_STRIDE2_EN
  localparam bit STRIDE = 1'b1;
`else
  localparam bit STRIDE = 1'b0;
`endif
  localparam int WPF4  = STRIDE ? 1 : 4;
  localparam int WPF28 = STRIDE ? 169 : 676;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        iv4 = 1'b0, wr4 = 1'b0, ir4, wv4, fd4;
  logic [7:0]  id4 = 8'h00;
  logic [71:0] wd4;
  logic        iv28 = 1'b0, wr28 = 1'b0, ir28, wv28, fd28;
  logic [7:0]  id28 = 8'h00;
  logic [71:0] wd28;

  int ntests = 0;
  int nfail  = 0;

  window_sequencer #(.IMG_W(4), .IMG_H(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_data(id4), .in_ready(ir4),
    .win_valid(wv4), .win_data(wd4), .win_ready(wr4), .frame_done(fd4)
  );

  window_sequencer #(.IMG_W(28), .IMG_H(28)) u_dut28 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv28), .in_data(id28), .in_ready(ir28),
    .win_valid(wv28), .win_data(wd28), .win_ready(wr28), .frame_done(fd28)
  );

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      if (nfail <= 40) $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit emits(input int r, input int c);
    return (r >= 2) && (c >= 2) && (!STRIDE || ((r % 2 == 0) && (c % 2 == 0)));
  endfunction

  // ---------------- scoreboard, 4x4 ----------------
  logic [7:0]  img4 [4][4];
  logic [71:0] q4 [$];
  int r4 = 0, c4 = 0, cons4 = 0;
  bit fdp4 = 1'b0;

  function automatic logic [71:0] build4(input int r, input int c);
    logic [71:0] w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[8*(3*i+j) +: 8] = img4[r-2+i][c-2+j];
    return w;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      r4 = 0; c4 = 0; fdp4 = 1'b0; q4.delete();
    end else begin
      check("sb4_valid", 72'(wv4), 72'(q4.size() != 0));
      if (wv4 && q4.size() != 0) check("sb4_data", wd4, q4[0]);
      check("sb4_frame_done", 72'(fd4), 72'(fdp4));
      fdp4 = 1'b0;
      if (wv4 && wr4) begin
        if (q4.size() != 0) void'(q4.pop_front());
        cons4++;
      end
      if (iv4 && ir4) begin
        img4[r4][c4] = id4;
        if (emits(r4, c4)) q4.push_back(build4(r4, c4));
        fdp4 = (r4 == 3) && (c4 == 3);
        if (c4 == 3) begin c4 = 0; r4 = (r4 == 3) ? 0 : r4 + 1; end
        else c4++;
      end
    end
  end

  // ---------------- scoreboard, 28x28 ----------------
  logic [7:0]  img28 [28][28];
  logic [71:0] q28 [$];
  int r28 = 0, c28 = 0, cons28 = 0, acc28 = 0;
  bit fdp28 = 1'b0;

  function automatic logic [71:0] build28(input int r, input int c);
    logic [71:0] w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[8*(3*i+j) +: 8] = img28[r-2+i][c-2+j];
    return w;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      r28 = 0; c28 = 0; fdp28 = 1'b0; q28.delete();
    end else begin
      check("sb28_valid", 72'(wv28), 72'(q28.size() != 0));
      if (wv28 && q28.size() != 0) check("sb28_data", wd28, q28[0]);
      check("sb28_frame_done", 72'(fd28), 72'(fdp28));
      fdp28 = 1'b0;
      if (wv28 && wr28) begin
        if (q28.size() != 0) void'(q28.pop_front());
        cons28++;
      end
      if (iv28 && ir28) begin
        img28[r28][c28] = id28;
        if (emits(r28, c28)) q28.push_back(build28(r28, c28));
        fdp28 = (r28 == 27) && (c28 == 27);
        acc28++;
        if (c28 == 27) begin c28 = 0; r28 = (r28 == 27) ? 0 : r28 + 1; end
        else c28++;
      end
    end
  end

  // ---------------- directed vectors, 4x4 ----------------
  typedef struct {
    logic [7:0]  pix;
    logic        ev;
    logic [71:0] ed;
    logic        efd;
  } vec_t;
  vec_t tbl [16];

  task automatic do_reset();
    iv4 = 1'b0; wr4 = 1'b0; iv28 = 1'b0; wr28 = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_win_valid", 72'(wv4), 72'(0));
    check("rst_win_data", wd4, 72'(0));
    check("rst_frame_done", 72'(fd4), 72'(0));
    check("rst_in_ready", 72'(ir4), 72'(1));
    rst_n = 1'b1;
  endtask

  task automatic feed4(input logic [7:0] p, input logic wr);
    iv4 = 1'b1; id4 = p; wr4 = wr;
    @(posedge clk);
    #1;
  endtask

  task automatic run_table();
    check("in_ready_after_reset", 72'(ir4), 72'(1));
    for (int k = 0; k < 16; k++) begin
      feed4(tbl[k].pix, 1'b1);
      check("tbl_win_valid", 72'(wv4), 72'(tbl[k].ev));
      if (tbl[k].ev) check("tbl_win_data", wd4, tbl[k].ed);
      check("tbl_frame_done", 72'(fd4), 72'(tbl[k].efd));
      $display("[TB] pix %02h win_valid %b win_data %h frame_done %b", tbl[k].pix, wv4, wd4, fd4);
    end
    iv4 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int budget;
    for (int k = 0; k < 16; k++) tbl[k] = '{pix: 8'(k), ev: 1'b0, ed: 72'h0, efd: 1'b0};
    tbl[10].ev = 1'b1; tbl[10].ed = 72'h0A0908060504020100;
    if (!STRIDE) begin
      tbl[11].ev = 1'b1; tbl[11].ed = 72'h0B0A09070605030201;
      tbl[14].ev = 1'b1; tbl[14].ed = 72'h0E0D0C0A0908060504;
      tbl[15].ev = 1'b1; tbl[15].ed = 72'h0F0E0D0B0A09070605;
    end
    tbl[15].efd = 1'b1;

    // Basic stream.
    do_reset();
    cons4 = 0;
    run_table();
    check("basic_window_count", 72'(cons4), 72'(WPF4));

    // Stall after first window.
    do_reset();
    cons4 = 0;
    for (int p = 0; p <= 10; p++) feed4(8'(p), 1'b1);
    for (int s = 0; s < 5; s++) begin
      iv4 = 1'b1; id4 = 8'h0B; wr4 = 1'b0;
      #1;
      check("stall_in_ready", 72'(ir4), 72'(0));
      @(posedge clk);
      #1;
      check("stall_win_valid", 72'(wv4), 72'(1));
      check("stall_win_data", wd4, 72'h0A0908060504020100);
    end
    for (int p = 11; p <= 15; p++) feed4(8'(p), 1'b1);
    check("stall_frame_done", 72'(fd4), 72'(1));
    iv4 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("stall_window_count", 72'(cons4), 72'(WPF4));

    // Two frames back to back.
    do_reset();
    cons4 = 0;
    for (int p = 0; p < 32; p++) begin
      feed4(8'(p), 1'b1);
      if (p >= 16 && p <= 23) check("f2_rows01_quiet", 72'(wv4), 72'(0));
      if (p == 15 || p == 31) check("f2_frame_done", 72'(fd4), 72'(1));
      if (p == 26) begin
        check("f2_first_valid", 72'(wv4), 72'(1));
        check("f2_first_data", wd4, 72'h1A1918161514121110);
      end
    end
    iv4 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("f2_window_count", 72'(cons4), 72'(2 * WPF4));

    // Reset in the middle of a frame.
    do_reset();
    for (int p = 0; p <= 6; p++) feed4(8'(p), 1'b1);
    iv4 = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_win_valid", 72'(wv4), 72'(0));
    check("midrst_win_data", wd4, 72'(0));
    check("midrst_in_ready", 72'(ir4), 72'(1));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cons4 = 0;
    run_table();
    check("midrst_window_count", 72'(cons4), 72'(WPF4));

    // Random throttling on the 28x28 instance, one frame at a time.
    do_reset();
    acc28 = 0;
    for (int f = 1; f <= 2; f++) begin
      cons28 = 0;
      budget = 0;
      while (acc28 < f * 784 && budget < 20000) begin
        iv28 = ($urandom_range(0, 3) != 0);
        wr28 = ($urandom_range(0, 3) != 0);
        id28 = 8'($urandom);
        @(posedge clk);
        #1;
        budget++;
      end
      check("rand_budget", 72'(budget < 20000), 72'(1));
      iv28 = 1'b0;
      wr28 = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("rand_windows_per_frame", 72'(cons28), 72'(WPF28));
      check("rand_queue_empty", 72'(q28.size()), 72'(0));
      $display("[TB] frame %0d: %0d windows", f, cons28);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
